peridot_phy_rxd: RTL
====================

Name: peridot_phy_rxd

Overview:
- UART receiver phy: the receive-side counterpart of the host bridge's UART sender phy.
- Samples the asynchronous rxd line, frames 8N1 characters (LSB first), and presents each byte on an Avalon-ST source (ready/valid).
- Sits between the board RX pin and the host bridge byte-stream logic.
- Single clock domain; rxd is the only asynchronous input.

Parameters:
- CLOCK_FREQUENCY, 50000000, clock_sig frequency in Hz.
- UART_BAUDRATE, 115200, line rate in bit/s.
- Derived local CLOCK_DIVNUM = CLOCK_FREQUENCY/UART_BAUDRATE - 1 (433 at defaults); must fit 12 bits.
- Derived local HALF_DIVNUM = CLOCK_DIVNUM/2, integer division (216 at defaults).

Ports:
- clock_sig  in  1  clock; all logic on the rising edge.
- reset_sig  in  1  reset; asynchronous, active-high.
- out_ready  in  1  sink can accept a byte.
- out_valid  out  1  out_data holds a received byte.
- out_data  out  8  received byte, bit0 = first data bit on the line.
- out_ferr  out  1  one-cycle pulse: stop bit sampled low, byte discarded.
- out_ovr  out  1  one-cycle pulse: byte completed while the buffer was still full, new byte discarded.
- rxd  in  1  UART line, idle high, asynchronous.

Behaviour:
- Reset values:
  - out_valid=0, out_data=8'h00, out_ferr=0, out_ovr=0.
  - Both synchronizer flops = 1, state=IDLE, divcount=0, bitcount=0, shift register=0.
- Synchronizer: rxd passes through a 2-flop synchronizer. All FSM decisions use the second flop (rxd_s).
- 12-bit down-counter divcount; 4-bit bitcount.
- FSM states and transitions:
  - IDLE: rxd_s==0 -> START, divcount<=HALF_DIVNUM.
  - START:
    - divcount!=0 -> decrement.
    - divcount==0 and rxd_s==1 -> IDLE (glitch rejected, no pulse).
    - divcount==0 and rxd_s==0 -> DATA, divcount<=CLOCK_DIVNUM, bitcount<=8.
  - DATA:
    - divcount==0 -> shift rxd_s into the MSB (right shift), divcount<=CLOCK_DIVNUM, bitcount-1.
    - When bitcount==1 at that sample -> STOP.
  - STOP, at divcount==0:
    - rxd_s==1 -> deliver the byte, go to IDLE (re-arms at mid-stop-bit, so back-to-back characters are accepted).
    - rxd_s==0 -> out_ferr pulse, go to BREAK.
  - BREAK: wait for rxd_s==1 -> IDLE. No start detection while held low (break condition).
- Latency: from the first clock edge that sees rxd low at the pin, out_valid rises after edge 4+HALF_DIVNUM+9*(CLOCK_DIVNUM+1), i.e. 4126 clocks at defaults.
- Deliver rules:
  - out_valid==0, or out_valid==1 with out_ready==1 in the same cycle: out_data<=byte, out_valid<=1. Load wins over consume, so out_valid stays 1.
  - Otherwise: out_ovr pulses, the old byte is kept, the new byte is lost.
- Handshake:
  - A transfer occurs on a cycle with out_valid&out_ready.
  - out_valid clears the next cycle unless a delivery coincides.
  - out_data is stable while out_valid=1 and no transfer has occurred.
- Reset mid-character: everything returns to reset values immediately. The partial byte is lost and no pulses are generated.

Decomposition:
- Shared package peridot_uart_pkg holds:
  - a constant function for the divider value (F/B-1) and half divider, used by both tx and rx phys;
  - 3-bit state encodings IDLE/START/DATA/STOP/BREAK;
  - the frame constants DATA_BITS=8 and the 12-bit divcount width.
- One natural sub-module: peridot_sync2, the 2-flop synchronizer with reset value 1 (reusable for other async pins).

Test Plan:
- Send 8'h55, then 8'hA3 back-to-back at 115200 with out_ready=1 -> out_valid pulses with out_data 55 then A3; first valid 4126 clocks after the start edge; out_ferr=0, out_ovr=0.
- 3-clock low glitch on rxd while idle -> no out_valid, no pulses; a following valid frame 8'h0F is received correctly.
- Frame 8'h81 with stop bit forced 0, rxd held low for 2 more bit-times, then a frame 8'h42 -> one out_ferr pulse, no out_valid for 81, then 42 delivered.
- out_ready=0, send 8'h11 then 8'h22 -> out_valid=1 with 11 held, out_ovr pulses once at 22's stop sample, out_data stays 11. Raise out_ready -> transfer of 11, then out_valid=0.
- out_ready raised on the exact cycle the next byte 8'h33 completes while 8'h11 is pending -> 11 transferred, out_data=33, out_valid stays 1, no out_ovr.
- Assert reset_sig mid-data of frame 8'hFF -> outputs at reset values; the next frame 8'h5A is received correctly.

Source files
------------

// File: rtl/peridot_uart_pkg.sv
// Shared UART phy definitions: frame constants, FSM encoding and baud divider helpers.
// Used by both the transmit and receive phys.
package peridot_uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int DIVCNT_W  = 12;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  // Clocks per bit minus one: the reload value of the bit-period down-counter.
  function automatic int uart_divnum(input int clk_hz, input int baud);
    return (clk_hz / baud) - 1;
  endfunction

  function automatic int uart_halfdiv(input int clk_hz, input int baud);
    return uart_divnum(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/peridot_sync2.sv
// Two-flop synchronizer for an asynchronous input pin; both flops reset high
// so an idle-high line does not produce a false edge out of reset.
module peridot_sync2 (
  input  logic clock_sig,
  input  logic reset_sig,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Metastability filter chain.
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/peridot_phy_rxd.sv
// UART 8N1 receiver phy: samples rxd mid-bit and presents each byte on an
// Avalon-ST source with framing-error and overrun pulses.
module peridot_phy_rxd
  import peridot_uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int UART_BAUDRATE   = 115200
) (
  input  logic       clock_sig,
  input  logic       reset_sig,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_ferr,
  output logic       out_ovr,
  input  logic       rxd
);

  localparam logic [DIVCNT_W-1:0] CLOCK_DIVNUM =
    DIVCNT_W'(uart_divnum(CLOCK_FREQUENCY, UART_BAUDRATE));
  localparam logic [DIVCNT_W-1:0] HALF_DIVNUM =
    DIVCNT_W'(uart_halfdiv(CLOCK_FREQUENCY, UART_BAUDRATE));

  logic                rxd_s;
  uart_state_e         state_q, state_d;
  logic [DIVCNT_W-1:0] divcount_q, divcount_d;
  logic [3:0]          bitcount_q, bitcount_d;
  logic [7:0]          shift_q, shift_d;
  logic                valid_q, valid_d;
  logic [7:0]          data_q, data_d;
  logic                ferr_q, ferr_d;
  logic                ovr_q, ovr_d;

  peridot_sync2 u_sync (
    .clock_sig (clock_sig),
    .reset_sig (reset_sig),
    .d_i       (rxd),
    .q_o       (rxd_s)
  );

  // State and output registers.
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state_q    <= IDLE;
      divcount_q <= '0;
      bitcount_q <= 4'd0;
      shift_q    <= 8'h00;
      valid_q    <= 1'b0;
      data_q     <= 8'h00;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      divcount_q <= divcount_d;
      bitcount_q <= bitcount_d;
      shift_q    <= shift_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  // Framing FSM and output buffer next-state.
  always_comb begin
    state_d    = state_q;
    divcount_d = divcount_q;
    bitcount_d = bitcount_q;
    shift_d    = shift_q;
    data_d     = data_q;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;

    // A delivery below overrides this consume, so valid stays high.
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d    = START;
          divcount_d = HALF_DIVNUM;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (divcount_q != '0) begin
          divcount_d = divcount_q - 12'd1;
        end else if (rxd_s) begin
          state_d = IDLE;
        end else begin
          state_d    = DATA;
          divcount_d = CLOCK_DIVNUM;
          bitcount_d = 4'(DATA_BITS);
        end
      end
      DATA: begin
        if (divcount_q == '0) begin
          shift_d    = {rxd_s, shift_q[7:1]};
          divcount_d = CLOCK_DIVNUM;
          bitcount_d = bitcount_q - 4'd1;
          if (bitcount_q == 4'd1) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          divcount_d = divcount_q - 12'd1;
        end
      end
      STOP: begin
        if (divcount_q != '0) begin
          divcount_d = divcount_q - 12'd1;
        end else if (rxd_s) begin
          state_d = IDLE;
          if (!valid_q || out_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          state_d = BREAK;
          ferr_d  = 1'b1;
        end
      end
      BREAK: begin
        if (rxd_s) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ferr  = ferr_q;
  assign out_ovr   = ovr_q;

endmodule
